// File: rtl/cpu_clock_sequencer.sv
// CPU core clock generator: free-run, single-step and N-step burst modes from probe-bus controls.
// Optional breakpoint halt is compiled in with `define CPU_CLK_BREAKPOINT_EN.

module cpu_clock_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV_WIDTH   = 24,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned BURST_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_auto_en,
    input  logic                   clk_step,
    input  logic [DIV_WIDTH-1:0]   half_period,
    input  logic [BURST_WIDTH-1:0] step_count,
`ifdef CPU_CLK_BREAKPOINT_EN
    input  logic                   bp_enable,
    input  logic [7:0]             bp_addr,
    input  logic [7:0]             cpu_addr,
    output logic                   bp_hit,
`endif
    output logic                   cpu_clk,
    output logic                   cpu_rise,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   cycle_count
);

    typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

    logic [SYNC_STAGES-1:0] auto_sync_q;
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic                   auto_s;
    logic                   step_s;
    logic                   step_prev_q;
    logic                   step_req_q;

    state_e                 state_q;
    logic [DIV_WIDTH-1:0]   phase_cnt_q;
    logic [BURST_WIDTH-1:0] burst_left_q;
    logic                   cpu_clk_q;
    logic                   cpu_rise_q;
    logic                   busy_q;
    logic [CNT_WIDTH-1:0]   cycle_count_q;

    logic [DIV_WIDTH-1:0]   phase_load;
    logic [BURST_WIDTH-1:0] burst_load;
    logic                   phase_end;
    logic                   auto_go;
    logic                   bp_hold;
    logic                   bp_match;
    logic                   go_high;
    logic                   go_low;
    logic                   go_idle;
    logic [BURST_WIDTH-1:0] burst_next;

    // Synchronizers; shift form keeps SYNC_STAGES=1 legal.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_sync_q <= '0;
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
            step_req_q  <= 1'b0;
        end else begin
            auto_sync_q <= (auto_sync_q << 1) | SYNC_STAGES'(clk_auto_en);
            step_sync_q <= (step_sync_q << 1) | SYNC_STAGES'(clk_step);
            step_prev_q <= step_s;
            step_req_q  <= step_s & ~step_prev_q;
        end
    end

    assign auto_s = auto_sync_q[SYNC_STAGES-1];
    assign step_s = step_sync_q[SYNC_STAGES-1];

    always_comb begin
        phase_load = '0;
        if (half_period != '0) begin
            phase_load = half_period - DIV_WIDTH'(1);
        end
        burst_load = step_count;
        if (step_count == '0) begin
            burst_load = BURST_WIDTH'(1);
        end
    end

    assign phase_end = (phase_cnt_q == '0);
    assign auto_go   = auto_s & ~bp_hold;

`ifdef CPU_CLK_BREAKPOINT_EN
    logic bp_hit_q;
    logic bp_skip_q;
    logic auto_prev_q;

    assign bp_hold  = bp_hit_q;
    assign bp_match = bp_enable && (cpu_addr == bp_addr) && !bp_skip_q;
    assign bp_hit   = bp_hit_q;

    // Skip flag lets the first pulse of a resuming step leave the breakpoint address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_hit_q    <= 1'b0;
            bp_skip_q   <= 1'b0;
            auto_prev_q <= 1'b0;
        end else begin
            auto_prev_q <= auto_s;
            if (state_q == StLow && phase_end && bp_match) begin
                bp_hit_q <= 1'b1;
            end else if (step_req_q || (auto_s && !auto_prev_q)) begin
                bp_hit_q <= 1'b0;
            end
            if (state_q == StIdle && !auto_go && step_req_q && bp_hit_q) begin
                bp_skip_q <= 1'b1;
            end else if (state_q == StLow && phase_end) begin
                bp_skip_q <= 1'b0;
            end
        end
    end
`else
    assign bp_hold  = 1'b0;
    assign bp_match = 1'b0;
`endif

    always_comb begin
        go_high    = 1'b0;
        go_low     = 1'b0;
        go_idle    = 1'b0;
        burst_next = burst_left_q;
        unique case (state_q)
            StIdle: begin
                if (auto_go) begin
                    go_high    = 1'b1;
                    burst_next = BURST_WIDTH'(1);
                end else if (step_req_q) begin
                    go_high    = 1'b1;
                    burst_next = burst_load;
                end
            end
            StHigh: begin
                go_low = phase_end;
            end
            StLow: begin
                if (phase_end) begin
                    if (bp_match) begin
                        go_idle = 1'b1;
                    end else if (auto_s) begin
                        // Free-run overrides any burst; a later auto drop then stops after one LOW.
                        go_high    = 1'b1;
                        burst_next = BURST_WIDTH'(1);
                    end else begin
                        burst_next = burst_left_q - BURST_WIDTH'(1);
                        if (burst_next != '0) begin
                            go_high = 1'b1;
                        end else begin
                            go_idle = 1'b1;
                        end
                    end
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            phase_cnt_q   <= '0;
            burst_left_q  <= '0;
            cpu_clk_q     <= 1'b0;
            cpu_rise_q    <= 1'b0;
            busy_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            cpu_rise_q   <= 1'b0;
            burst_left_q <= burst_next;
            if (go_high) begin
                state_q       <= StHigh;
                phase_cnt_q   <= phase_load;
                cpu_clk_q     <= 1'b1;
                cpu_rise_q    <= 1'b1;
                busy_q        <= 1'b1;
                cycle_count_q <= cycle_count_q + CNT_WIDTH'(1);
            end else if (go_low) begin
                state_q     <= StLow;
                phase_cnt_q <= phase_load;
                cpu_clk_q   <= 1'b0;
            end else if (go_idle) begin
                state_q     <= StIdle;
                phase_cnt_q <= '0;
                cpu_clk_q   <= 1'b0;
                busy_q      <= 1'b0;
            end else if (state_q != StIdle) begin
                phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
            end
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_rise    = cpu_rise_q;
    assign busy        = busy_q;
    assign cycle_count = cycle_count_q;

endmodule
